// File: rtl/cache_way_merge_arbiter.sv
// Round-robin merge of NREQ way-index requesters into one registered output; 1-cycle latency.
// Backpressure: when the output is FULL and out_ready=0, no requester is granted and the output holds.
module cache_way_merge_arbiter #(
  parameter int NREQ = 2,
  parameter int DW   = 2,
  parameter int SW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [SW-1:0]        out_src,
  input  logic                 out_ready
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_ptr;
  logic [SW-1:0]   w_win;
  logic [SW-1:0]   w_ptr_nxt;
  logic            w_any;
  logic            w_hi_found;
  logic            w_can_load;
  logic            w_accept;
  logic [NREQ-1:0] w_grant;

  // Two-pass scan: lowest valid index at or above the pointer, else lowest valid overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_win      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i >= int'(r_ptr))) begin
        w_hi_found = 1'b1;
        w_win      = SW'(i);
      end
    end
    if (!w_hi_found) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (req_valid[i]) begin
          w_win = SW'(i);
        end
      end
    end
  end

  assign w_any     = |req_valid;
  assign w_grant   = w_any ? (NREQ'(1) << w_win) : '0;
  assign w_ptr_nxt = (w_win == SW'(NREQ - 1)) ? '0 : (w_win + SW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: w_state_nxt = w_any ? S_FULL : S_EMPTY;
      S_FULL: begin
        if (out_ready) begin
          w_state_nxt = w_any ? S_FULL : S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    out_valid  = (r_state == S_FULL);
    w_can_load = (r_state == S_EMPTY) | out_ready;
    w_accept   = w_any & w_can_load;
    req_ready  = rst ? (w_grant & {NREQ{w_can_load}}) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data <= '0;
      out_src  <= '0;
      r_ptr    <= '0;
    end else if (w_accept) begin
      out_data <= req_data[w_win*DW +: DW];
      out_src  <= w_win;
      r_ptr    <= w_ptr_nxt;
    end
  end

endmodule
